// File: rtl/proc_rf_sequencer_pkg.sv
// Shared types and constants for the register-file instruction-cycle sequencer.
package proc_rf_sequencer_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned STATE_WIDTH    = 3;
    localparam int unsigned OPCODE_WIDTH   = 6;

    // Instruction field positions
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned FUNCT_LSB  = 0;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXE    = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_MEM  = 2'd1,
        WB_SEL_LINK = 2'd2
    } wb_sel_e;

    // Write-back decode result
    typedef struct packed {
        logic                      en;
        wb_sel_e                   sel;
        logic [REG_ADDR_WIDTH-1:0] addr;
    } wb_dec_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_JAL   = 6'h03;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_WIDTH-1:0] OP_SLTI  = 6'h0a;
    localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 6'h0c;
    localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = 6'h0d;
    localparam logic [OPCODE_WIDTH-1:0] OP_LUI   = 6'h0f;
    localparam logic [OPCODE_WIDTH-1:0] OP_MULI  = 6'h1d;
    localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_WIDTH-1:0] FN_JR    = 6'h08;

    localparam logic [REG_ADDR_WIDTH-1:0] LINK_REG = 5'd31;

endpackage

// File: rtl/proc_rf_sequencer_rf_wb_decode.sv
// Combinational write-back class decode: which register to write and from which source.
module rf_wb_decode
    import proc_rf_sequencer_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0]   opcode_i,
    input  logic [OPCODE_WIDTH-1:0]   funct_i,
    input  logic [REG_ADDR_WIDTH-1:0] rt_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_i,
    output wb_dec_t                   wb_dec_c_o
);

    logic                      en;
    wb_sel_e                   sel;
    logic [REG_ADDR_WIDTH-1:0] addr;

    // Classify the opcode; r0 destinations never produce a write strobe
    always_comb begin
        en   = 1'b0;
        sel  = WB_SEL_ALU;
        addr = '0;
        case (opcode_i)
            OP_RTYPE: begin
                if (funct_i != FN_JR) begin
                    en   = 1'b1;
                    addr = rd_i;
                end
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_MULI: begin
                en   = 1'b1;
                addr = rt_i;
            end
            OP_LW: begin
                en   = 1'b1;
                sel  = WB_SEL_MEM;
                addr = rt_i;
            end
            OP_JAL: begin
                en   = 1'b1;
                sel  = WB_SEL_LINK;
                addr = LINK_REG;
            end
            default: begin
                en = 1'b0;
            end
        endcase
        wb_dec_c_o.en   = en && (addr != '0);
        wb_dec_c_o.sel  = sel;
        wb_dec_c_o.addr = addr;
    end

endmodule

// File: rtl/proc_rf_sequencer.sv
// Five-state FETCH/DECODE/EXE/MEM/WB sequencer driving the 32x32 register file ports.
module proc_rf_sequencer
    import proc_rf_sequencer_pkg::*;
(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      HOLD,
    input  logic [DATA_WIDTH-1:0]     INSTR,
    input  logic [DATA_WIDTH-1:0]     ALU_RESULT,
    input  logic [DATA_WIDTH-1:0]     MEM_DATA,
    input  logic [DATA_WIDTH-1:0]     PC,
    output logic [STATE_WIDTH-1:0]    STATE,
    output logic [DATA_WIDTH-1:0]     INSTR_REG,
    output logic [REG_ADDR_WIDTH-1:0] ADDR_R1,
    output logic [REG_ADDR_WIDTH-1:0] ADDR_R2,
    output logic [REG_ADDR_WIDTH-1:0] ADDR_W,
    output logic [DATA_WIDTH-1:0]     DATA_W,
    output logic                      READ,
    output logic                      WRITE
);

    state_e                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     instr_q, instr_d;
    logic [DATA_WIDTH-1:0]     link_q, link_d;
    logic [DATA_WIDTH-1:0]     alu_q, alu_d;
    logic [REG_ADDR_WIDTH-1:0] addr_r1_q, addr_r1_d;
    logic [REG_ADDR_WIDTH-1:0] addr_r2_q, addr_r2_d;
    logic [REG_ADDR_WIDTH-1:0] addr_w_q, addr_w_d;
    logic [DATA_WIDTH-1:0]     data_w_q, data_w_d;
    logic                      read_q, read_d;
    logic                      write_q, write_d;
    wb_dec_t                   wb_dec;

    // Write-back class of the latched instruction
    rf_wb_decode u_wb_decode (
        .opcode_i   (instr_q[OPCODE_LSB +: OPCODE_WIDTH]),
        .funct_i    (instr_q[FUNCT_LSB +: OPCODE_WIDTH]),
        .rt_i       (instr_q[RT_LSB +: REG_ADDR_WIDTH]),
        .rd_i       (instr_q[RD_LSB +: REG_ADDR_WIDTH]),
        .wb_dec_c_o (wb_dec)
    );

    // Next-state and next-output logic; HOLD freezes every register
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        link_d    = link_q;
        alu_d     = alu_q;
        addr_r1_d = addr_r1_q;
        addr_r2_d = addr_r2_q;
        addr_w_d  = addr_w_q;
        data_w_d  = data_w_q;
        read_d    = read_q;
        write_d   = write_q;
        if (!HOLD) begin
            read_d  = 1'b0;
            write_d = 1'b0;
            case (state_q)
                ST_FETCH: begin
                    state_d   = ST_DECODE;
                    instr_d   = INSTR;
                    addr_r1_d = INSTR[RS_LSB +: REG_ADDR_WIDTH];
                    addr_r2_d = INSTR[RT_LSB +: REG_ADDR_WIDTH];
                    link_d    = PC + DATA_WIDTH'(1);
                    read_d    = 1'b1;
                end
                ST_DECODE: begin
                    state_d = ST_EXE;
                end
                ST_EXE: begin
                    state_d = ST_MEM;
                    alu_d   = ALU_RESULT;
                end
                ST_MEM: begin
                    // DATA_W itself is the memory-data latch for loads
                    state_d  = ST_WB;
                    addr_w_d = wb_dec.addr;
                    write_d  = wb_dec.en;
                    case (wb_dec.sel)
                        WB_SEL_MEM:  data_w_d = MEM_DATA;
                        WB_SEL_LINK: data_w_d = link_q;
                        default:     data_w_d = alu_q;
                    endcase
                end
                ST_WB: begin
                    state_d = ST_FETCH;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    // State, latch and output registers with asynchronous clear
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_FETCH;
            instr_q   <= '0;
            link_q    <= '0;
            alu_q     <= '0;
            addr_r1_q <= '0;
            addr_r2_q <= '0;
            addr_w_q  <= '0;
            data_w_q  <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            link_q    <= link_d;
            alu_q     <= alu_d;
            addr_r1_q <= addr_r1_d;
            addr_r2_q <= addr_r2_d;
            addr_w_q  <= addr_w_d;
            data_w_q  <= data_w_d;
            read_q    <= read_d;
            write_q   <= write_d;
        end
    end

    assign STATE     = state_q;
    assign INSTR_REG = instr_q;
    assign ADDR_R1   = addr_r1_q;
    assign ADDR_R2   = addr_r2_q;
    assign ADDR_W    = addr_w_q;
    assign DATA_W    = data_w_q;
    assign READ      = read_q;
    assign WRITE     = write_q;

endmodule

// File: tb/tb_proc_rf_sequencer.sv
// Self-checking bench: vector table per instruction plus hold and mid-WB reset sequences.
module tb_proc_rf_sequencer;

    logic        CLK;
    logic        RST;
    logic        HOLD;
    logic [31:0] INSTR;
    logic [31:0] ALU_RESULT;
    logic [31:0] MEM_DATA;
    logic [31:0] PC;
    logic [2:0]  STATE;
    logic [31:0] INSTR_REG;
    logic [4:0]  ADDR_R1;
    logic [4:0]  ADDR_R2;
    logic [4:0]  ADDR_W;
    logic [31:0] DATA_W;
    logic        READ;
    logic        WRITE;

    proc_rf_sequencer dut (
        .CLK        (CLK),
        .RST        (RST),
        .HOLD       (HOLD),
        .INSTR      (INSTR),
        .ALU_RESULT (ALU_RESULT),
        .MEM_DATA   (MEM_DATA),
        .PC         (PC),
        .STATE      (STATE),
        .INSTR_REG  (INSTR_REG),
        .ADDR_R1    (ADDR_R1),
        .ADDR_R2    (ADDR_R2),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .READ       (READ),
        .WRITE      (WRITE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        we;
        logic        chk_addr;
        logic [4:0]  aw;
        logic        chk_data;
        logic [31:0] dw;
    } vec_t;

    vec_t vecs[12];
    vec_t sb[$];
    int   n_pass;
    int   n_total;

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] alu, input logic [31:0] mem,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic we, input logic chk_addr, input logic [4:0] aw,
                                input logic chk_data, input logic [31:0] dw);
        vec_t v;
        v.instr = instr; v.pc = pc; v.alu = alu; v.mem = mem;
        v.r1 = r1; v.r2 = r2; v.we = we;
        v.chk_addr = chk_addr; v.aw = aw; v.chk_data = chk_data; v.dw = dw;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drive one instruction through all five states and check every cycle
    task automatic run_vec(input vec_t v, input string tag);
        vec_t e;
        logic [2:0] exp_st;
        INSTR = v.instr; PC = v.pc; ALU_RESULT = v.alu; MEM_DATA = v.mem;
        sb.push_back(v);
        for (int c = 1; c <= 5; c++) begin
            step();
            exp_st = 3'(c % 5);
            check($sformatf("%s.state%0d", tag, c), 32'(STATE), 32'(exp_st));
            check($sformatf("%s.read%0d", tag, c), 32'(READ), 32'(exp_st == 3'd1));
            if (exp_st == 3'd1) begin
                check($sformatf("%s.instr_reg", tag), INSTR_REG, v.instr);
                check($sformatf("%s.addr_r1", tag), 32'(ADDR_R1), 32'(v.r1));
                check($sformatf("%s.addr_r2", tag), 32'(ADDR_R2), 32'(v.r2));
            end
            if (STATE == 3'd4) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL %s.sb: WB reached with empty scoreboard", tag);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("%s.write", tag), 32'(WRITE), 32'(e.we));
                    if (e.chk_addr) check($sformatf("%s.addr_w", tag), 32'(ADDR_W), 32'(e.aw));
                    if (e.chk_data) check($sformatf("%s.data_w", tag), DATA_W, e.dw);
                end
            end else begin
                check($sformatf("%s.write%0d", tag, c), 32'(WRITE), 32'd0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        n_pass = 0;
        n_total = 0;

        //            instr         pc            alu           mem           r1  r2  we  ca  aw  cd  dw
        vecs[0]  = mk(32'h00430820, 32'h00000010, 32'hDEADBEEF, 32'h00000000, 2,  3,  1,  1,  1,  1,  32'hDEADBEEF);
        vecs[1]  = mk(32'h8C450004, 32'h00000011, 32'h00000006, 32'h12345678, 2,  5,  1,  1,  5,  1,  32'h12345678);
        vecs[2]  = mk(32'h0C000010, 32'hFFFFFFFF, 32'h11111111, 32'h22222222, 0,  0,  1,  1,  31, 1,  32'h00000000);
        vecs[3]  = mk(32'h20000007, 32'h00000020, 32'h00000007, 32'h33333333, 0,  0,  0,  1,  0,  0,  32'h0);
        vecs[4]  = mk(32'hAC450004, 32'h00000021, 32'h00000006, 32'h44444444, 2,  5,  0,  0,  0,  0,  32'h0);
        vecs[5]  = mk(32'h00000008, 32'h00000022, 32'h55555555, 32'h66666666, 0,  0,  0,  0,  0,  0,  32'h0);
        vecs[6]  = mk(32'h346700FF, 32'h00000030, 32'h000000FF, 32'h77777777, 3,  7,  1,  1,  7,  1,  32'h000000FF);
        vecs[7]  = mk(32'h3C1F1234, 32'h00000031, 32'h12340000, 32'h88888888, 0,  31, 1,  1,  31, 1,  32'h12340000);
        vecs[8]  = mk(32'h74890003, 32'h00000032, 32'h0000002A, 32'h99999999, 4,  9,  1,  1,  9,  1,  32'h0000002A);
        vecs[9]  = mk(32'h03DDF822, 32'h00000033, 32'hA5A5A5A5, 32'hBBBBBBBB, 30, 29, 1,  1,  31, 1,  32'hA5A5A5A5);
        vecs[10] = mk(32'h00430020, 32'h00000034, 32'hCCCCCCCC, 32'hDDDDDDDD, 2,  3,  0,  1,  0,  0,  32'h0);
        vecs[11] = mk(32'h10430005, 32'h00000035, 32'hEEEEEEEE, 32'hFFFFFFFF, 2,  3,  0,  0,  0,  0,  32'h0);

        RST = 1'b0; HOLD = 1'b0;
        INSTR = 32'hFFFFFFFF; PC = 32'h0; ALU_RESULT = 32'h0; MEM_DATA = 32'h0;
        repeat (3) step();
        check("rst.state", 32'(STATE), 32'd0);
        check("rst.instr_reg", INSTR_REG, 32'd0);
        check("rst.addr_r1", 32'(ADDR_R1), 32'd0);
        check("rst.addr_r2", 32'(ADDR_R2), 32'd0);
        check("rst.addr_w", 32'(ADDR_W), 32'd0);
        check("rst.data_w", DATA_W, 32'd0);
        check("rst.read", 32'(READ), 32'd0);
        check("rst.write", 32'(WRITE), 32'd0);
        RST = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // add held for 3 clocks in WB, plus a hold in DECODE and mid-cycle HOLD glitch
        v = mk(32'h00430820, 32'h00000040, 32'hCAFEF00D, 32'h0, 2, 3, 1, 1, 1, 1, 32'hCAFEF00D);
        INSTR = v.instr; PC = v.pc; ALU_RESULT = v.alu; MEM_DATA = v.mem;
        step();
        check("hold.dec_state", 32'(STATE), 32'd1);
        HOLD = 1'b1;
        step();
        check("hold.dec_state_held", 32'(STATE), 32'd1);
        check("hold.dec_read_held", 32'(READ), 32'd1);
        HOLD = 1'b0;
        #2 HOLD = 1'b1;
        #2 HOLD = 1'b0;
        step();
        check("hold.glitch_state", 32'(STATE), 32'd2);
        step();
        step();
        check("hold.wb_state", 32'(STATE), 32'd4);
        check("hold.wb_write", 32'(WRITE), 32'd1);
        HOLD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold.state%0d", i), 32'(STATE), 32'd4);
            check($sformatf("hold.write%0d", i), 32'(WRITE), 32'd1);
            check($sformatf("hold.addr_w%0d", i), 32'(ADDR_W), 32'd1);
            check($sformatf("hold.data_w%0d", i), DATA_W, 32'hCAFEF00D);
        end
        HOLD = 1'b0;
        step();
        check("hold.release_state", 32'(STATE), 32'd0);
        check("hold.release_write", 32'(WRITE), 32'd0);

        // Reset pulsed in the middle of a WB cycle
        INSTR = 32'h00851020; ALU_RESULT = 32'h0BADF00D; PC = 32'h50;
        repeat (4) step();
        check("rstwb.pre_write", 32'(WRITE), 32'd1);
        check("rstwb.pre_addr_w", 32'(ADDR_W), 32'd2);
        #3 RST = 1'b0;
        #1;
        check("rstwb.state", 32'(STATE), 32'd0);
        check("rstwb.write", 32'(WRITE), 32'd0);
        check("rstwb.addr_w", 32'(ADDR_W), 32'd0);
        check("rstwb.data_w", DATA_W, 32'd0);
        #2 RST = 1'b1;

        // First edge after release must fetch
        run_vec(vecs[1], "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/proc_rf_sequencer.md
# proc_rf_sequencer

Five-state instruction-cycle sequencer that drives the 32x32 register file's read and write ports. It latches the fetched instruction and decodes source and destination fields. It asserts READ in DECODE and WRITE in WB, and selects the write-back data from the ALU result, memory data or PC+1. It sits directly upstream of REGISTER_FILE_32x32: its ADDR_R1/ADDR_R2/ADDR_W/DATA_W/READ/WRITE outputs connect one-to-one to that block's inputs.

## Interface
- DATA_WIDTH, 32, datapath width (`DATA_WIDTH)
- REG_ADDR_WIDTH, 5, register index width (`REG_ADDR_INDEX_LIMIT+1)
- CLK  input  1  system clock, rising-edge active
- RST  input  1  reset: asynchronous, active-low
- HOLD  input  1  stall: freezes the sequencer when 1
- INSTR  input  DATA_WIDTH  instruction word from memory, sampled at the end of FETCH
- ALU_RESULT  input  DATA_WIDTH  sampled at the end of EXE
- MEM_DATA  input  DATA_WIDTH  sampled at the end of MEM
- PC  input  DATA_WIDTH  current PC, sampled at the end of FETCH
- STATE  output  3  current state encoding
- INSTR_REG  output  DATA_WIDTH  latched instruction
- ADDR_R1, ADDR_R2  output  REG_ADDR_WIDTH  rs, rt read addresses
- ADDR_W  output  REG_ADDR_WIDTH  write-back address
- DATA_W  output  DATA_WIDTH  write-back data
- READ, WRITE  output  1  register-file strobes

## Operation
- States: FETCH=3'd0, DECODE=3'd1, EXE=3'd2, MEM=3'd3, WB=3'd4.
- With HOLD=0, the state advances one step per edge: FETCH→DECODE→EXE→MEM→WB→FETCH. Codes 5–7 are illegal and go to FETCH on the next edge.
- FETCH→DECODE edge latches:
  - INSTR into INSTR_REG;
  - ADDR_R1 = INSTR[25:21];
  - ADDR_R2 = INSTR[20:16];
  - PC+1 into an internal link register (mod 2^32, wraps silently).
- EXE→MEM edge: latch ALU_RESULT.
- MEM→WB edge: latch MEM_DATA.
- Write-back class, decoded from INSTR_REG[31:26] and [5:0]:
  - R-type, opcode 0x00 with funct ≠ 0x08: ADDR_W = rd [15:11], DATA_W = ALU latch.
  - addi 0x08, slti 0x0a, andi 0x0c, ori 0x0d, lui 0x0f, muli 0x1d: ADDR_W = rt, DATA_W = ALU latch.
  - lw 0x23: ADDR_W = rt, DATA_W = MEM latch.
  - jal 0x03: ADDR_W = 5'd31, DATA_W = link register.
  - All other opcodes, and jr: no write.
- WRITE=1 only in WB, only for a writing class, and only when ADDR_W ≠ 0. Writes to r0 are suppressed.
- READ=1 only in DECODE. READ and WRITE are never both 1.
- Outside DECODE and WB, READ=WRITE=0. The register file then floats DATA_R1/DATA_R2, which is expected.
- HOLD=1 at an edge holds everything unchanged: state, latches, and every output including a READ or WRITE already asserted. A write held in WB is re-applied with the same address and data, which is idempotent.
- Reset (RST=0, asynchronous):
  - state = FETCH;
  - INSTR_REG, ADDR_R1, ADDR_R2, ADDR_W and DATA_W = 0;
  - READ = WRITE = 0;
  - all internal latches = 0.
- Reset during WB aborts the write immediately; no partial write is committed beyond the current edge.
- Release: the first FETCH→DECODE transition happens on the first rising edge with RST=1 and HOLD=0.

## Timing
- All outputs are registered and update on the edge that enters the state they belong to.
- READ is high for exactly one cycle, coincident with STATE==DECODE. ADDR_R1/ADDR_R2 are stable from the DECODE entry edge until the next FETCH→DECODE edge.
- ADDR_W, DATA_W and WRITE become valid on the MEM→WB edge, stay valid for the whole WB cycle, and return to WRITE=0 on the WB→FETCH edge. The register file captures the write within that cycle.
- Cycle latency: 5 clocks per instruction when HOLD is never asserted. Each cycle with HOLD=1 adds exactly one clock.
- HOLD is sampled only at rising edges. HOLD changing mid-cycle has no effect.

## Structure
- State codes, opcode/funct constants and the r31 link index go in prj_definition.v, alongside `DATA_WIDTH/`REG_ADDR_INDEX_LIMIT.
- One combinational sub-module, rf_wb_decode: INSTR_REG → {wb_en, wb_sel[1:0] (ALU/MEM/LINK), wb_addr}.
- The top level holds the state register, latches and output registers, roughly 200 RTL lines total.

## Test plan
- Reset then release with HOLD=0 → STATE cycles 0,1,2,3,4,0. READ=1 only in cycle 1, WRITE=1 only in cycle 4.
- INSTR=32'h00430820 (add r1,r2,r3), ALU_RESULT=32'hDEADBEEF in EXE → DECODE gives ADDR_R1=2, ADDR_R2=3. WB gives ADDR_W=1, DATA_W=32'hDEADBEEF, WRITE=1.
- INSTR=32'h8C450004 (lw r5,4(r2)), MEM_DATA=32'h12345678 in MEM → WB gives ADDR_W=5, DATA_W=32'h12345678, WRITE=1.
- INSTR=32'h0C000010 (jal), PC=32'hFFFFFFFF → WB gives ADDR_W=31, DATA_W=32'h00000000 (wrap), WRITE=1.
- INSTR=32'h20000007 (addi r0) and INSTR=32'hAC450004 (sw) → WRITE stays 0 for the whole cycle. INSTR=32'h00000008 (jr) → WRITE stays 0.
- HOLD=1 for 3 clocks during WB of an add → WRITE stays 1 for 4 cycles with constant ADDR_W/DATA_W. Then RST=0 pulsed mid-WB → WRITE=0 and STATE=0 immediately, without waiting for a clock edge.
